// File: rtl/soc_timer_pkg.sv
// Shared constants and types for the memory-mapped SoC timer.
package soc_timer_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned OFFS_WIDTH = 12;

  localparam logic [OFFS_WIDTH-1:0] TIMER_CTRL_OFFS     = 12'h000;
  localparam logic [OFFS_WIDTH-1:0] TIMER_PRESCALE_OFFS = 12'h004;
  localparam logic [OFFS_WIDTH-1:0] TIMER_COMPARE_OFFS  = 12'h008;
  localparam logic [OFFS_WIDTH-1:0] TIMER_COUNT_OFFS    = 12'h00C;
  localparam logic [OFFS_WIDTH-1:0] TIMER_STATUS_OFFS   = 12'h010;

  localparam int unsigned TIMER_CTRL_EN_BIT         = 0;
  localparam int unsigned TIMER_CTRL_AUTORELOAD_BIT = 1;
  localparam int unsigned TIMER_CTRL_IE_BIT         = 2;

  // Field order mirrors the CTRL bit positions so a cast to [2:0] is the register image.
  typedef struct packed {
    logic ie;
    logic autoreload;
    logic en;
  } timer_ctrl_t;

  function automatic logic [DATA_WIDTH-1:0] apply_wstrb(input logic [DATA_WIDTH-1:0] old_val,
                                                        input logic [DATA_WIDTH-1:0] new_val,
                                                        input logic [3:0]            strb);
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/soc_timer_if.sv
// Peripheral bus between the SoC address decoder (master) and the timer (slave).
interface soc_timer_if
  import soc_timer_pkg::*;
#(
  parameter int unsigned DW = DATA_WIDTH,
  parameter int unsigned AW = OFFS_WIDTH
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output rvalid, rdata
  );
endinterface

// File: rtl/soc_timer_prescaler.sv
// Free-running prescaler: emits a one-cycle tick every limit+1 enabled cycles.
module soc_timer_prescaler
  import soc_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic             tick
);

  logic [WIDTH-1:0] pcnt_q, pcnt_d;

  assign tick = en & (pcnt_q == limit);

  always_comb begin
    pcnt_d = pcnt_q + 1'b1;
    if (!en || clr || tick) pcnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/soc_timer.sv
// 32-bit timer peripheral: register file, compare/auto-reload counter and level interrupt.
module soc_timer
  import soc_timer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = soc_timer_pkg::DATA_WIDTH,
  parameter int unsigned OFFS_WIDTH = soc_timer_pkg::OFFS_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  soc_timer_if.slave bus,
  output logic       irq
);

  timer_ctrl_t           ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] prescale_q, prescale_d;
  logic [DATA_WIDTH-1:0] compare_q, compare_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  pend_q, pend_d;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [OFFS_WIDTH-1:0] offs;
  logic                  wr, rd;
  logic                  wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
  logic                  en_clear, presc_en, presc_clr, tick, match;
  logic                  unused_addr;

  assign offs        = {bus.addr[OFFS_WIDTH-1:2], 2'b00};
  assign unused_addr = ^bus.addr[1:0];
  assign wr          = bus.req & bus.we;
  assign rd          = bus.req & ~bus.we;
  assign wr_ctrl     = wr & (offs == TIMER_CTRL_OFFS);
  assign wr_prescale = wr & (offs == TIMER_PRESCALE_OFFS);
  assign wr_compare  = wr & (offs == TIMER_COMPARE_OFFS);
  assign wr_count    = wr & (offs == TIMER_COUNT_OFFS);
  assign wr_status   = wr & (offs == TIMER_STATUS_OFFS);

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl && bus.wstrb[0]) ctrl_d = timer_ctrl_t'(bus.wdata[2:0]);
  end

  // A write that drops EN kills a tick landing on the same edge.
  assign en_clear  = wr_ctrl & ~ctrl_d.en;
  assign presc_en  = ctrl_q.en & ~en_clear;
  assign presc_clr = wr_prescale | wr_count;

  soc_timer_prescaler #(
    .WIDTH (DATA_WIDTH)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (presc_en),
    .clr   (presc_clr),
    .limit (prescale_q),
    .tick  (tick)
  );

  assign match = tick & ~wr_count & (count_q == compare_q);

  always_comb begin
    prescale_d = wr_prescale ? apply_wstrb(prescale_q, bus.wdata, bus.wstrb) : prescale_q;
    compare_d  = wr_compare  ? apply_wstrb(compare_q, bus.wdata, bus.wstrb)  : compare_q;

    count_d = count_q;
    if (wr_count) begin
      count_d = apply_wstrb(count_q, bus.wdata, bus.wstrb);
    end else if (tick) begin
      count_d = (match && ctrl_q.autoreload) ? '0 : count_q + 1'b1;
    end

    // Set has priority over the W1C clear.
    pend_d = pend_q;
    if (wr_status && bus.wstrb[0] && bus.wdata[0]) pend_d = 1'b0;
    if (match) pend_d = 1'b1;
  end

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      case (offs)
        TIMER_CTRL_OFFS:     rdata_d = {{(DATA_WIDTH-3){1'b0}}, ctrl_q};
        TIMER_PRESCALE_OFFS: rdata_d = prescale_q;
        TIMER_COMPARE_OFFS:  rdata_d = compare_q;
        TIMER_COUNT_OFFS:    rdata_d = count_q;
        TIMER_STATUS_OFFS:   rdata_d = {{(DATA_WIDTH-1){1'b0}}, pend_q};
        default:             rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      compare_q  <= '0;
      count_q    <= '0;
      pend_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      compare_q  <= compare_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      rvalid_q   <= bus.req;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign irq        = pend_q & ctrl_q.ie;

endmodule

// File: doc/soc_timer.md
Name: soc_timer

Overview:
- Memory-mapped 32-bit timer peripheral. It occupies the TIMER_BASE window (32'h1000_2000) of the SoC peripheral map.
- Sits directly downstream of the SoC address decoder. The decoder asserts req only for addresses inside the 4 KB timer window and forwards the word offset.
- Provides a programmable prescaler, a compare match with optional auto-reload, and a level interrupt to the core.

Parameters:
- DATA_WIDTH, 32, register and bus data width (from soc_pkg); the block supports only 32.
- OFFS_WIDTH, 12, width of the in-window byte offset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  1  bus access valid this cycle; the decoder has already matched TIMER_BASE
- we  in  1  1 = write, 0 = read
- addr  in  OFFS_WIDTH  byte offset in window; bits [1:0] are ignored
- wdata  in  DATA_WIDTH  write data
- wstrb  in  4  byte write enables
- rvalid  out  1  response valid, exactly one cycle after each req (reads and writes)
- rdata  out  DATA_WIDTH  read data, valid when rvalid=1, otherwise 0
- irq  out  1  level interrupt

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is synchronous and active-high.
  - On rst, all registers, rvalid, rdata and irq are 0.
- Register map (offset):
  - 0x00 CTRL: [0] EN, [1] AUTORELOAD, [2] IE; other bits read 0.
  - 0x04 PRESCALE: 32-bit R/W.
  - 0x08 COMPARE: 32-bit R/W.
  - 0x0C COUNT: 32-bit R/W.
  - 0x10 STATUS: [0] PEND, write-1-to-clear.
  - Any other offset reads 0; writes to it are ignored. rvalid is still returned.
- Bus:
  - The block is always ready; no back-pressure.
  - Writes apply byte-wise per wstrb at the clock edge where req&we=1.
  - Reads sample register state at the req edge. rdata is registered and presented with rvalid on the next cycle.
  - Back-to-back req on consecutive cycles is legal.
- Prescaler:
  - Internal 32-bit pcnt. While EN=1, pcnt increments each cycle.
  - When pcnt==PRESCALE, a one-cycle tick is generated and pcnt returns to 0. A tick therefore occurs every PRESCALE+1 cycles.
  - pcnt is cleared when EN=0 and on any write to PRESCALE or COUNT.
- Counter, on each tick:
  - If COUNT==COMPARE: PEND<=1. COUNT<=0 if AUTORELOAD=1, else COUNT<=COUNT+1.
  - Otherwise: COUNT<=COUNT+1. Addition is modulo 2^32, so 0xFFFF_FFFF wraps to 0.
  - With EN=0, COUNT holds its value.
- Simultaneous events:
  - A bus write to COUNT in the same cycle as a tick: the bus write wins; no match is evaluated that cycle.
  - A STATUS W1C in the same cycle as a new match: set wins, PEND stays 1.
  - A write to COMPARE takes effect for the next tick.
  - Clearing EN in the same cycle as a tick: the tick is suppressed.
- irq = PEND & IE, driven from flops only (no combinational path from bus inputs).
- Reset mid-transaction: a req in the rst cycle is dropped and no rvalid is produced.

Decomposition:
- soc_pkg additions:
  - Register offset localparams: TIMER_CTRL_OFFS, TIMER_PRESCALE_OFFS, TIMER_COMPARE_OFFS, TIMER_COUNT_OFFS, TIMER_STATUS_OFFS.
  - CTRL bit index constants.
  - A packed struct timer_ctrl_t.
- One natural sub-module: soc_timer_prescaler. It takes clk, rst, en, clr and limit, and outputs tick.
- Register file and counter logic stay in soc_timer.

Test Plan:
1. Reset, then read every offset 0x00–0x10 and 0x20 -> all rdata=0, rvalid exactly 1 cycle after each req, irq=0.
2. PRESCALE=0, COMPARE=3, CTRL=0b111 -> COUNT sequence 1,2,3,0,1…; PEND and irq rise on the cycle COUNT returns to 0; writing STATUS=1 drops irq next cycle.
3. PRESCALE=4, COMPARE=0xFFFF_FFFF, AUTORELOAD=0, COUNT=0xFFFF_FFFE, EN=1 -> COUNT changes every 5 cycles; after 2 ticks COUNT=0 and PEND=1; it next reaches 1 without reloading.
4. Arrange a tick edge coinciding with a bus write COUNT=0x100 -> COUNT=0x100, no increment. Separately, W1C of STATUS on a match cycle -> PEND remains 1.
5. Write CTRL with wstrb=0b0010 and wdata=0xFFFF_FFFF -> CTRL unchanged (=0). Write COMPARE with wstrb=0b0001 and wdata=0xAABB_CCDD -> COMPARE=0x0000_00DD.
6. Assert rst while counting with irq=1 and a read req pending -> next cycle all outputs 0, COUNT=0, no rvalid for the dropped req.
